wb2ahb: RTL and testbench

Wishbone-slave to AHB-master bridge: the reverse-direction companion of the AHB-to-Wishbone bridge. It accepts classic single Wishbone cycles from a local Wishbone master, requests the AHB bus, and performs one SINGLE/NONSEQ AHB transfer per Wishbone cycle. It then returns the data and the ack/err/rty status to the Wishbone side. The bridge sits between a Wishbone-only core (DMA, peripheral master) and the AMBA AHB fabric.

---
 rtl/wb2ahb.sv | 213 +++++++++++++++++++++
 tb/tb_wb2ahb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb2ahb.sv
// Wishbone-slave to AHB-master bridge.
//
// Accepts one classic single Wishbone cycle at a time, requests the AHB bus and
// issues a single NONSEQ transfer. The data and the ack/err/rty status then
// return to the Wishbone master. All outputs are registered.
//
// Ports
//   hclk, hreset                  clock, synchronous active-high reset
//   wbs_adr_i/dat_i/sel_i/we_i    Wishbone request (sel encodes the size: 1/3/F)
//   wbs_stb_i, wbs_cyc_i          Wishbone strobe / cycle
//   wbs_dat_o                     read data, valid with wbs_ack_o
//   wbs_ack_o/err_o/rty_o         one-cycle termination pulses
//   hbusreq, hlock, hgrant        AHB arbitration (hlock tied low)
//   htrans, haddr, hwrite, hsize,
//   hburst, hprot, hwdata         AHB master request
//   hready, hresp, hrdata         AHB slave response
module wb2ahb #(
  parameter int unsigned HAMAX = 8,
  parameter int unsigned HDMAX = 8
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic [HAMAX-1:0] wbs_adr_i,
  input  logic [HDMAX-1:0] wbs_dat_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic             wbs_we_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  output logic [HDMAX-1:0] wbs_dat_o,
  output logic             wbs_ack_o,
  output logic             wbs_err_o,
  output logic             wbs_rty_o,
  output logic             hbusreq,
  output logic             hlock,
  input  logic             hgrant,
  input  logic             hready,
  input  logic [1:0]       hresp,
  input  logic [HDMAX-1:0] hrdata,
  output logic [1:0]       htrans,
  output logic [HAMAX-1:0] haddr,
  output logic             hwrite,
  output logic [2:0]       hsize,
  output logic [HDMAX-1:0] hwdata,
  output logic [2:0]       hburst,
  output logic [3:0]       hprot
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] RespOkay    = 2'b00;
  localparam logic [1:0] RespError   = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAddr,
    StData,
    StResp,
    StErr2
  } state_e;

  state_e           state_q, state_d;
  logic             hbusreq_q, hbusreq_d;
  logic [1:0]       htrans_q, htrans_d;
  logic [HAMAX-1:0] haddr_q, haddr_d;
  logic             hwrite_q, hwrite_d;
  logic [2:0]       hsize_q, hsize_d;
  logic [HDMAX-1:0] hwdata_q, hwdata_d;
  logic [HDMAX-1:0] dat_q, dat_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             rty_q, rty_d;
  // Set once the master drops cyc after the AHB transfer has been committed;
  // the transfer still finishes but its termination pulse is swallowed.
  logic             abort_q, abort_d;

  logic             size_ok;
  logic [2:0]       size_enc;
  logic             term_ok;

  always_comb begin
    size_ok  = 1'b1;
    size_enc = 3'd0;
    case (wbs_sel_i)
      4'h1:    size_enc = 3'd0;
      4'h3:    size_enc = 3'd1;
      4'hF:    size_enc = 3'd2;
      default: size_ok  = 1'b0;
    endcase
  end

  assign term_ok = wbs_cyc_i & ~abort_q;

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    dat_d    = dat_q;
    abort_d  = abort_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rty_d    = 1'b0;

    case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (wbs_cyc_i && wbs_stb_i) begin
          if (size_ok) begin
            haddr_d  = wbs_adr_i;
            hwrite_d = wbs_we_i;
            hsize_d  = size_enc;
            hwdata_d = wbs_dat_i;
            state_d  = StReq;
          end else begin
            // Unsupported byte-select pattern: reject without touching AHB.
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StReq: begin
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (hgrant && hready) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (!wbs_cyc_i) abort_d = 1'b1;
        if (hready) state_d = StData;
      end
      StData: begin
        if (!wbs_cyc_i) abort_d = 1'b1;
        if (hready) begin
          state_d = StResp;
          if (hresp == RespOkay) begin
            ack_d = term_ok;
            if (term_ok) dat_d = hrdata;
          end else begin
            // Single-cycle error response is a protocol violation; still terminate.
            err_d = term_ok & (hresp == RespError);
            rty_d = term_ok & (hresp != RespError);
          end
        end else if (hresp != RespOkay) begin
          state_d = StErr2;
        end
      end
      StErr2: begin
        if (!wbs_cyc_i) abort_d = 1'b1;
        if (hready) begin
          state_d = StResp;
          err_d   = term_ok & (hresp == RespError);
          rty_d   = term_ok & (hresp != RespError);
        end
      end
      StResp: begin
        abort_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    hbusreq_d = (state_d == StReq);
    htrans_d  = (state_d == StAddr) ? TransNonseq : TransIdle;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= StIdle;
      hbusreq_q <= 1'b0;
      htrans_q  <= TransIdle;
      haddr_q   <= '0;
      hwrite_q  <= 1'b0;
      hsize_q   <= 3'd0;
      hwdata_q  <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rty_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hbusreq_q <= hbusreq_d;
      htrans_q  <= htrans_d;
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      hsize_q   <= hsize_d;
      hwdata_q  <= hwdata_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rty_q     <= rty_d;
      abort_q   <= abort_d;
    end
  end

  assign hbusreq   = hbusreq_q;
  assign hlock     = 1'b0;
  assign htrans    = htrans_q;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hwdata    = hwdata_q;
  assign hburst    = 3'b000;
  assign hprot     = 4'b0011;
  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_rty_o = rty_q;

endmodule

// File: tb/tb_wb2ahb.sv
// Bench for wb2ahb: a directed Wishbone master, a scripted AHB slave and a
// scoreboard monitor that checks every termination pulse against the queue.
module tb_wb2ahb;

  logic       hclk = 1'b0;
  logic       hreset = 1'b1;
  logic [7:0] wbs_adr_i = '0;
  logic [7:0] wbs_dat_i = '0;
  logic [3:0] wbs_sel_i = '0;
  logic       wbs_we_i = 1'b0;
  logic       wbs_stb_i = 1'b0;
  logic       wbs_cyc_i = 1'b0;
  logic [7:0] wbs_dat_o;
  logic       wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic       hbusreq, hlock;
  logic       hgrant = 1'b0;
  logic       hready = 1'b1;
  logic [1:0] hresp = 2'b00;
  logic [7:0] hrdata = '0;
  logic [1:0] htrans;
  logic [7:0] haddr;
  logic       hwrite;
  logic [2:0] hsize;
  logic [7:0] hwdata;
  logic [2:0] hburst;
  logic [3:0] hprot;

  wb2ahb #(.HAMAX(8), .HDMAX(8)) dut (
    .hclk(hclk), .hreset(hreset),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbs_rty_o(wbs_rty_o), .hbusreq(hbusreq), .hlock(hlock), .hgrant(hgrant),
    .hready(hready), .hresp(hresp), .hrdata(hrdata), .htrans(htrans),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hburst(hburst), .hprot(hprot)
  );

  always #5 hclk = ~hclk;

  int cyc_cnt = 0;
  always @(posedge hclk) cyc_cnt <= cyc_cnt + 1;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: kind 0=ack 1=err 2=rty; cyc is the cyc_cnt at the sampling negedge.
  typedef struct {
    int         kind;
    logic       chk_d;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  always @(negedge hclk) begin
    if (!hreset && (wbs_ack_o || wbs_err_o || wbs_rty_o)) begin
      int   k;
      exp_t e;
      k = wbs_ack_o ? 0 : (wbs_err_o ? 1 : 2);
      chk("term_onehot", 32'(wbs_ack_o) + 32'(wbs_err_o) + 32'(wbs_rty_o), 1);
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_term: got kind %0d at cycle %0d, expected none", k, cyc_cnt);
      end else begin
        e = sb.pop_front();
        chk("term_kind", k, e.kind);
        chk("term_cycle", cyc_cnt, e.cyc);
        if (e.chk_d) chk("read_data", wbs_dat_o, e.data);
      end
    end
  end

  // Scripted AHB slave, updated on the falling edge.
  int         s_gdly = 0;
  int         s_ws = 0;
  logic [1:0] s_resp = 2'b00;
  logic [7:0] s_rdata = '0;
  int         gcnt = 0;
  int         ws = 0;
  logic       in_data = 1'b0;
  logic       errph = 1'b0;

  always @(negedge hclk) begin
    hgrant = 1'b0;
    hready = 1'b1;
    hresp  = 2'b00;
    if (hreset) begin
      in_data = 1'b0;
      gcnt    = 0;
    end else begin
      if (in_data) begin
        if (ws < s_ws) begin
          hready = 1'b0;
          ws++;
        end else if (s_resp == 2'b00) begin
          hrdata  = s_rdata;
          in_data = 1'b0;
        end else if (!errph) begin
          hready = 1'b0;
          hresp  = s_resp;
          errph  = 1'b1;
        end else begin
          hresp   = s_resp;
          in_data = 1'b0;
        end
      end
      if (htrans == 2'b10) begin
        in_data = 1'b1;
        ws      = 0;
        errph   = 1'b0;
      end
      if (hbusreq) begin
        hgrant = (gcnt >= s_gdly);
        gcnt++;
      end else begin
        gcnt = 0;
      end
    end
  end

  // Observations captured by wb_xfer.
  logic       addr_seen, busreq_seen, done;
  logic [7:0] cap_haddr, cap_hwdata;
  logic       cap_hwrite;
  logic [2:0] cap_hsize;
  logic [1:0] cap_htrans_next;

  // One Wishbone cycle held until any termination; called at a negedge.
  task automatic wb_xfer(input logic [7:0] adr, input logic [7:0] dat, input logic [3:0] sel,
                         input logic we, input int gdly, input int wst, input logic [1:0] resp,
                         input logic [7:0] rdata, input int kind, input logic chk_d,
                         input int lat);
    exp_t e;
    logic after_addr;
    s_gdly  = gdly;
    s_ws    = wst;
    s_resp  = resp;
    s_rdata = rdata;
    e.kind  = kind;
    e.chk_d = chk_d;
    e.data  = rdata;
    e.cyc   = cyc_cnt + lat;
    sb.push_back(e);
    addr_seen   = 1'b0;
    busreq_seen = 1'b0;
    done        = 1'b0;
    after_addr  = 1'b0;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    wbs_we_i  = we;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge hclk);
      if (after_addr) begin
        cap_htrans_next = htrans;
        cap_hwdata      = hwdata;
        after_addr      = 1'b0;
      end
      if (htrans == 2'b10 && !addr_seen) begin
        addr_seen  = 1'b1;
        after_addr = 1'b1;
        cap_haddr  = haddr;
        cap_hwrite = hwrite;
        cap_hsize  = hsize;
      end
      if (hbusreq) busreq_seen = 1'b1;
      if (wbs_ack_o || wbs_err_o || wbs_rty_o) begin
        done = 1'b1;
        break;
      end
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    chk("xfer_done", done, 1);
    @(negedge hclk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hbusreq"}, hbusreq, 0);
    chk({tag, "_htrans"}, htrans, 0);
    chk({tag, "_haddr"}, haddr, 0);
    chk({tag, "_hwrite"}, hwrite, 0);
    chk({tag, "_hsize"}, hsize, 0);
    chk({tag, "_hwdata"}, hwdata, 0);
    chk({tag, "_dat_o"}, wbs_dat_o, 0);
    chk({tag, "_ack"}, wbs_ack_o, 0);
    chk({tag, "_err"}, wbs_err_o, 0);
    chk({tag, "_rty"}, wbs_rty_o, 0);
  endtask

  initial begin
    logic seen;
    repeat (3) @(negedge hclk);
    chk_reset_outputs("rst");
    chk("hburst", hburst, 3'b000);
    chk("hprot", hprot, 4'b0011);
    chk("hlock", hlock, 0);
    hreset = 1'b0;
    @(negedge hclk);

    // Zero-wait write: ack 4 cycles after stb.
    wb_xfer(8'h5A, 8'hC3, 4'h1, 1'b1, 0, 0, 2'b00, 8'h00, 0, 1'b0, 4);
    chk("wr_addr_seen", addr_seen, 1);
    chk("wr_haddr", cap_haddr, 8'h5A);
    chk("wr_hwrite", cap_hwrite, 1);
    chk("wr_hsize", cap_hsize, 3'd0);
    chk("wr_htrans_after", cap_htrans_next, 2'b00);
    chk("wr_hwdata", cap_hwdata, 8'hC3);

    // Read, grant delayed 3, two wait states: ack at 4+3+2.
    wb_xfer(8'h33, 8'h00, 4'h3, 1'b0, 3, 2, 2'b00, 8'h96, 0, 1'b1, 9);
    chk("rd_haddr", cap_haddr, 8'h33);
    chk("rd_hwrite", cap_hwrite, 0);
    chk("rd_hsize", cap_hsize, 3'd1);

    // Two-cycle ERROR response.
    wb_xfer(8'h10, 8'h11, 4'hF, 1'b1, 0, 0, 2'b01, 8'h00, 1, 1'b0, 5);
    chk("err_hsize", cap_hsize, 3'd2);
    chk("err_htrans_after", cap_htrans_next, 2'b00);

    // RETRY and SPLIT both terminate with rty; the bus request stays down.
    wb_xfer(8'h20, 8'h00, 4'h1, 1'b0, 0, 0, 2'b10, 8'h00, 2, 1'b0, 5);
    for (int i = 0; i < 3; i++) begin
      chk("retry_busreq_low", hbusreq, 0);
      @(negedge hclk);
    end
    wb_xfer(8'h21, 8'h00, 4'h1, 1'b0, 0, 1, 2'b11, 8'h00, 2, 1'b0, 6);
    chk("split_busreq_low", hbusreq, 0);

    // Illegal byte select: err next cycle, no bus request.
    wb_xfer(8'h40, 8'h00, 4'h5, 1'b0, 0, 0, 2'b00, 8'h00, 1, 1'b0, 1);
    chk("illegal_busreq", busreq_seen, 0);

    // Abort while requesting: grant never arrives, cyc drops.
    s_gdly    = 100;
    wbs_adr_i = 8'h77;
    wbs_sel_i = 4'h1;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge hclk);
      seen = hbusreq;
    end
    chk("abort_req_busreq_up", seen, 1);
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    @(negedge hclk);
    chk("abort_req_busreq_fall", hbusreq, 0);
    repeat (3) @(negedge hclk);

    // cyc dropped after the address phase: transfer completes silently.
    s_gdly    = 0;
    s_ws      = 3;
    s_resp    = 2'b00;
    wbs_adr_i = 8'h88;
    wbs_sel_i = 4'hF;
    wbs_we_i  = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge hclk);
      seen = (htrans == 2'b10);
    end
    chk("abort_addr_seen", seen, 1);
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    repeat (10) @(negedge hclk);
    chk("abort_addr_htrans", htrans, 0);
    chk("abort_addr_busreq", hbusreq, 0);

    // Reset during the data phase.
    s_ws      = 5;
    wbs_adr_i = 8'h99;
    wbs_dat_i = 8'h55;
    wbs_sel_i = 4'h1;
    wbs_we_i  = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge hclk);
      seen = (htrans == 2'b10);
    end
    chk("rstdata_addr_seen", seen, 1);
    @(negedge hclk);
    #1;
    hreset    = 1'b1;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    @(negedge hclk);
    chk_reset_outputs("midrst");
    #1 hreset = 1'b0;
    repeat (2) @(negedge hclk);

    // Bridge is usable again after the reset.
    wb_xfer(8'hE1, 8'h00, 4'hF, 1'b0, 0, 0, 2'b00, 8'hA5, 0, 1'b1, 4);
    chk("post_haddr", cap_haddr, 8'hE1);

    repeat (5) @(negedge hclk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
